// File: rtl/lc3_wb_pkg.sv
// Shared types, NZP encodings and scoreboard depth for the LC3 writeback stage.
package lc3_wb_pkg;

  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;
  typedef logic [2:0]  psr_t;

  localparam psr_t PSR_N    = 3'b100;
  localparam psr_t PSR_Z    = 3'b010;
  localparam psr_t PSR_P    = 3'b001;
  localparam int   MAX_PEND = 3;

  function automatic psr_t nzp_of(input word_t d);
    if (d[15])
      return PSR_N;
    else if (d == '0)
      return PSR_Z;
    else
      return PSR_P;
  endfunction

endpackage

// File: rtl/lc3_writeback_arbiter_if.sv
// Writeback bus: execute/memory commit sources, decode issue/hazard port, read ports, status.
interface lc3_writeback_arbiter_if;
  import lc3_wb_pkg::*;

  logic     ex_valid;
  logic     ex_ready;
  reg_idx_t ex_dr;
  word_t    ex_data;
  logic     ex_setcc;
  logic     mem_valid;
  reg_idx_t mem_dr;
  word_t    mem_data;
  logic     issue_valid;
  reg_idx_t issue_dr;
  logic     issue_ready;
  reg_idx_t sr1;
  reg_idx_t sr2;
  word_t    VSR1;
  word_t    VSR2;
  logic     sr1_busy;
  logic     sr2_busy;
  psr_t     psr;
  logic     enable_writeback_status;
  logic     wb_err;

  modport master (
    output ex_valid, ex_dr, ex_data, ex_setcc,
    output mem_valid, mem_dr, mem_data,
    output issue_valid, issue_dr, sr1, sr2,
    input  ex_ready, issue_ready, VSR1, VSR2, sr1_busy, sr2_busy,
    input  psr, enable_writeback_status, wb_err
  );

  modport slave (
    input  ex_valid, ex_dr, ex_data, ex_setcc,
    input  mem_valid, mem_dr, mem_data,
    input  issue_valid, issue_dr, sr1, sr2,
    output ex_ready, issue_ready, VSR1, VSR2, sr1_busy, sr2_busy,
    output psr, enable_writeback_status, wb_err
  );

endinterface

// File: rtl/lc3_wb_scoreboard.sv
// Per-register pending-write counters feeding decode hazard checks, plus sticky underflow flag.
module lc3_wb_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int MAX_PEND = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  lc3_wb_pkg::reg_idx_t issue_dr,
  input  logic                 commit,
  input  lc3_wb_pkg::reg_idx_t commit_dr,
  input  lc3_wb_pkg::reg_idx_t sr1,
  input  lc3_wb_pkg::reg_idx_t sr2,
  output logic                 issue_ready,
  output logic                 sr1_busy,
  output logic                 sr2_busy,
  output logic                 wb_err
);
  import lc3_wb_pkg::*;

  localparam int CW = $clog2(MAX_PEND + 1);
  typedef logic [CW-1:0] cnt_t;

  cnt_t cnt [NUM_REGS];
  logic issue_ok;
  logic inc [NUM_REGS];
  logic dec [NUM_REGS];

  assign issue_ready = (cnt[issue_dr] != cnt_t'(MAX_PEND));
  assign issue_ok    = issue_valid && issue_ready;
  assign sr1_busy    = (cnt[sr1] != '0);
  assign sr2_busy    = (cnt[sr2] != '0);

  // An issue and a commit to the same register cancel; decrement saturates at zero.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue_ok && (issue_dr == reg_idx_t'(i));
      dec[i] = commit && (commit_dr == reg_idx_t'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        cnt[i] <= '0;
      wb_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + cnt_t'(1);
        else if (dec[i] && !inc[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - cnt_t'(1);
      end
      if (commit && (cnt[commit_dr] == '0))
        wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/lc3_writeback_arbiter.sv
// LC3 writeback: memory-over-execute arbitration of the single regfile write port,
// write-through read ports, NZP condition codes and the pending-write scoreboard.
module lc3_writeback_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 3
) (
  input logic                    clock,
  input logic                    reset,
  lc3_writeback_arbiter_if.slave bus
);
  import lc3_wb_pkg::*;

  logic              commit;
  reg_idx_t          wr_dr;
  word_t             wr_data;
  logic              wr_setcc;
  logic [DATA_W-1:0] rf [NUM_REGS];
  psr_t              psr_q;
  logic              ews_q;

  // Load returns cannot stall, so execute is only accepted when memory is idle.
  assign bus.ex_ready = !bus.mem_valid;

  always_comb begin
    wr_dr    = bus.ex_dr;
    wr_data  = bus.ex_data;
    wr_setcc = bus.ex_setcc;
    if (bus.mem_valid) begin
      wr_dr    = bus.mem_dr;
      wr_data  = bus.mem_data;
      wr_setcc = 1'b1;
    end
  end

  // Qualified by reset so a commit presented while reset is held neither bypasses nor counts.
  assign commit = reset && (bus.mem_valid || (bus.ex_valid && bus.ex_ready));

  assign bus.VSR1 = (commit && (wr_dr == bus.sr1)) ? wr_data : rf[bus.sr1];
  assign bus.VSR2 = (commit && (wr_dr == bus.sr2)) ? wr_data : rf[bus.sr2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (commit) begin
      rf[wr_dr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psr_q <= PSR_Z;
      ews_q <= 1'b0;
    end else begin
      ews_q <= commit;
      if (commit && wr_setcc)
        psr_q <= nzp_of(wr_data);
    end
  end

  assign bus.psr                     = psr_q;
  assign bus.enable_writeback_status = ews_q;

  lc3_wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .MAX_PEND (MAX_PEND)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (bus.issue_valid),
    .issue_dr    (bus.issue_dr),
    .commit      (commit),
    .commit_dr   (wr_dr),
    .sr1         (bus.sr1),
    .sr2         (bus.sr2),
    .issue_ready (bus.issue_ready),
    .sr1_busy    (bus.sr1_busy),
    .sr2_busy    (bus.sr2_busy),
    .wb_err      (bus.wb_err)
  );

endmodule

// File: tb/tb_lc3_writeback_arbiter.sv
// Self-checking bench for lc3_writeback_arbiter: directed vector table, reset corner, randomized model check.
module tb_lc3_writeback_arbiter;
  import lc3_wb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lc3_writeback_arbiter_if bus();

  lc3_writeback_arbiter #(
    .NUM_REGS (8),
    .DATA_W   (16),
    .MAX_PEND (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state derived from the commit/issue rules.
  int m_rf  [8];
  int m_cnt [8];
  int m_psr;
  int m_ews;
  int m_err;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_rf[i]  = 0;
      m_cnt[i] = 0;
    end
    m_psr = 2;
    m_ews = 0;
    m_err = 0;
  endtask

  function automatic int m_commit();
    return (bus.mem_valid || bus.ex_valid) ? 1 : 0;
  endfunction

  function automatic int m_dr();
    return bus.mem_valid ? int'(bus.mem_dr) : int'(bus.ex_dr);
  endfunction

  function automatic int m_data();
    return bus.mem_valid ? int'(bus.mem_data) : int'(bus.ex_data);
  endfunction

  function automatic int m_read(input int s);
    if (m_commit() == 1 && m_dr() == s) return m_data();
    return m_rf[s];
  endfunction

  task automatic m_step();
    int c, d, v, cc, iok, idr;
    c   = m_commit();
    d   = m_dr();
    v   = m_data();
    cc  = (bus.mem_valid || bus.ex_setcc) ? 1 : 0;
    idr = int'(bus.issue_dr);
    iok = (bus.issue_valid && m_cnt[idr] < 3) ? 1 : 0;
    if (c == 1) begin
      m_rf[d] = v;
      if (cc == 1) m_psr = (v >= 32768) ? 4 : ((v == 0) ? 2 : 1);
      if (m_cnt[d] == 0) m_err = 1;
    end
    if (!(iok == 1 && c == 1 && idr == d)) begin
      if (iok == 1) m_cnt[idr] = m_cnt[idr] + 1;
      if (c == 1 && m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
    end
    m_ews = c;
  endtask

  task automatic drive(input int ev, input int edr, input int edata, input int esc,
                       input int mv, input int mdr, input int mdata,
                       input int iv, input int idr, input int s1, input int s2);
    bus.ex_valid    = ev[0];
    bus.ex_dr       = 3'(edr);
    bus.ex_data     = 16'(edata);
    bus.ex_setcc    = esc[0];
    bus.mem_valid   = mv[0];
    bus.mem_dr      = 3'(mdr);
    bus.mem_data    = 16'(mdata);
    bus.issue_valid = iv[0];
    bus.issue_dr    = 3'(idr);
    bus.sr1         = 3'(s1);
    bus.sr2         = 3'(s2);
  endtask

  task automatic check_model_comb(input string tag);
    chk({tag, ".ex_ready"},    bus.ex_ready,    bus.mem_valid ? 0 : 1);
    chk({tag, ".VSR1"},        bus.VSR1,        m_read(int'(bus.sr1)));
    chk({tag, ".VSR2"},        bus.VSR2,        m_read(int'(bus.sr2)));
    chk({tag, ".issue_ready"}, bus.issue_ready, (m_cnt[bus.issue_dr] < 3) ? 1 : 0);
    chk({tag, ".sr1_busy"},    bus.sr1_busy,    (m_cnt[bus.sr1] != 0) ? 1 : 0);
    chk({tag, ".sr2_busy"},    bus.sr2_busy,    (m_cnt[bus.sr2] != 0) ? 1 : 0);
  endtask

  task automatic check_model_reg(input string tag);
    chk({tag, ".psr"},         bus.psr,                     m_psr);
    chk({tag, ".ews"},         bus.enable_writeback_status, m_ews);
    chk({tag, ".wb_err"},      bus.wb_err,                  m_err);
    chk({tag, ".issue_ready"}, bus.issue_ready, (m_cnt[bus.issue_dr] < 3) ? 1 : 0);
    chk({tag, ".sr1_busy"},    bus.sr1_busy,    (m_cnt[bus.sr1] != 0) ? 1 : 0);
  endtask

  function automatic int pick_dr(input int prefer_pending);
    int r;
    if (prefer_pending == 1) begin
      for (int t = 0; t < 8; t++) begin
        r = int'($urandom_range(7, 0));
        if (m_cnt[r] > 0) return r;
      end
    end
    return int'($urandom_range(7, 0));
  endfunction

  function automatic int rand_word();
    case ($urandom_range(3, 0))
      0:       return 0;
      1:       return int'($urandom_range(65535, 32768));
      default: return int'($urandom_range(65535, 0));
    endcase
  endfunction

  task automatic rand_phase(input int n, input int legal);
    int ev, edr, edata, esc;
    for (int k = 0; k < n; k++) begin
      // A stalled execute offer must be held unchanged.
      if (bus.ex_valid && !bus.ex_ready) begin
        ev = 1; edr = int'(bus.ex_dr); edata = int'(bus.ex_data); esc = int'(bus.ex_setcc);
      end else begin
        ev    = ($urandom_range(2, 0) != 0) ? 1 : 0;
        edr   = pick_dr(legal);
        edata = rand_word();
        esc   = int'($urandom_range(1, 0));
      end
      drive(ev, edr, edata, esc,
            ($urandom_range(3, 0) == 0) ? 1 : 0, pick_dr(legal), rand_word(),
            int'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
            int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
      #2;
      check_model_comb("rand");
      @(posedge clock);
      m_step();
      #1;
      check_model_reg("rand");
      @(negedge clock);
    end
  endtask

  typedef struct {
    int ev, edr, edata, esc, mv, mdr, mdata, iv, idr, s1, s2;
    int x_rdy, x_v1, x_v2, x_ir, x_b1;
    int x_psr, x_ews, x_err, x_b1n, x_irn;
  } vec_t;

  vec_t tbl [18];

  initial begin
    //            ev edr edata  esc mv mdr mdata  iv idr s1 s2 | rdy v1      v2      ir b1 | psr ews err b1n irn
    tbl[0]  = '{0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 7,   1, 0,      0,      1, 0,   2, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0,      0, 0, 0, 0,      1, 3, 3, 3,   1, 0,      0,      1, 0,   2, 0, 0, 1, 1};
    tbl[2]  = '{1, 3, 'h8001, 1, 0, 0, 0,      0, 0, 3, 0,   1, 'h8001, 0,      1, 1,   4, 1, 0, 0, 1};
    tbl[3]  = '{0, 0, 0,      0, 0, 0, 0,      0, 0, 3, 3,   1, 'h8001, 'h8001, 1, 0,   4, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 0,      0, 0, 0, 0,      1, 2, 2, 0,   1, 0,      0,      1, 0,   4, 0, 0, 1, 1};
    tbl[5]  = '{0, 0, 0,      0, 0, 0, 0,      1, 5, 5, 2,   1, 0,      0,      1, 0,   4, 0, 0, 1, 1};
    tbl[6]  = '{1, 5, 'h1234, 1, 1, 2, 0,      0, 0, 2, 5,   0, 0,      0,      1, 1,   2, 1, 0, 0, 1};
    tbl[7]  = '{1, 5, 'h1234, 1, 0, 0, 0,      0, 0, 5, 2,   1, 'h1234, 0,      1, 1,   1, 1, 0, 0, 1};
    tbl[8]  = '{0, 0, 0,      0, 0, 0, 0,      1, 4, 4, 4,   1, 0,      0,      1, 0,   1, 0, 0, 1, 1};
    tbl[9]  = '{0, 0, 0,      0, 0, 0, 0,      1, 4, 4, 4,   1, 0,      0,      1, 1,   1, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 0,      0, 0, 0, 0,      1, 4, 4, 4,   1, 0,      0,      1, 1,   1, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 0,      0, 0, 0, 0,      1, 4, 4, 4,   1, 0,      0,      0, 1,   1, 0, 0, 1, 0};
    tbl[12] = '{1, 4, 'h0042, 0, 0, 0, 0,      0, 4, 4, 4,   1, 'h0042, 'h0042, 0, 1,   1, 1, 0, 1, 1};
    tbl[13] = '{0, 0, 0,      0, 0, 0, 0,      0, 4, 4, 3,   1, 'h0042, 'h8001, 1, 1,   1, 0, 0, 1, 1};
    tbl[14] = '{1, 4, 'h7fff, 1, 0, 0, 0,      0, 4, 4, 4,   1, 'h7fff, 'h7fff, 1, 1,   1, 1, 0, 1, 1};
    tbl[15] = '{0, 0, 0,      0, 1, 4, 'h0005, 0, 4, 4, 6,   0, 'h0005, 0,      1, 1,   1, 1, 0, 0, 1};
    tbl[16] = '{1, 6, 'hffff, 1, 0, 0, 0,      0, 6, 6, 4,   1, 'hffff, 'h0005, 1, 0,   4, 1, 1, 0, 1};
    tbl[17] = '{0, 0, 0,      0, 0, 0, 0,      0, 6, 6, 5,   1, 'hffff, 'h1234, 1, 0,   4, 0, 1, 0, 1};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(negedge clock);

    // Reset state: every register reads zero, status at reset values.
    for (int s = 0; s < 8; s++) begin
      bus.sr1 = 3'(s);
      bus.sr2 = 3'(7 - s);
      #1;
      chk("reset.VSR1", bus.VSR1, 0);
      chk("reset.VSR2", bus.VSR2, 0);
    end
    chk("reset.psr",         bus.psr, 2);
    chk("reset.ews",         bus.enable_writeback_status, 0);
    chk("reset.wb_err",      bus.wb_err, 0);
    chk("reset.issue_ready", bus.issue_ready, 1);
    chk("reset.ex_ready",    bus.ex_ready, 1);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ev, tbl[i].edr, tbl[i].edata, tbl[i].esc, tbl[i].mv, tbl[i].mdr,
            tbl[i].mdata, tbl[i].iv, tbl[i].idr, tbl[i].s1, tbl[i].s2);
      #2;
      chk($sformatf("vec%0d.ex_ready", i),    bus.ex_ready,    tbl[i].x_rdy);
      chk($sformatf("vec%0d.VSR1", i),        bus.VSR1,        tbl[i].x_v1);
      chk($sformatf("vec%0d.VSR2", i),        bus.VSR2,        tbl[i].x_v2);
      chk($sformatf("vec%0d.issue_ready", i), bus.issue_ready, tbl[i].x_ir);
      chk($sformatf("vec%0d.sr1_busy", i),    bus.sr1_busy,    tbl[i].x_b1);
      @(posedge clock);
      m_step();
      #1;
      chk($sformatf("vec%0d.psr", i),            bus.psr,                     tbl[i].x_psr);
      chk($sformatf("vec%0d.ews", i),            bus.enable_writeback_status, tbl[i].x_ews);
      chk($sformatf("vec%0d.wb_err", i),         bus.wb_err,                  tbl[i].x_err);
      chk($sformatf("vec%0d.sr1_busy_next", i),  bus.sr1_busy,                tbl[i].x_b1n);
      chk($sformatf("vec%0d.issue_ready_next", i), bus.issue_ready,           tbl[i].x_irn);
      @(negedge clock);
    end

    // Mid-stream reset: a commit to R1 first, then reset lands while a load is presented.
    drive(1, 1, 'h1111, 1, 0, 0, 0, 0, 0, 1, 3);
    @(posedge clock);
    m_step();
    #1;
    check_model_reg("prerst");
    @(negedge clock);
    drive(1, 3, 'h2222, 1, 1, 1, 'habcd, 1, 4, 1, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst.VSR1",        bus.VSR1, 0);
    chk("midrst.VSR2",        bus.VSR2, 0);
    chk("midrst.psr",         bus.psr, 2);
    chk("midrst.ews",         bus.enable_writeback_status, 0);
    chk("midrst.wb_err",      bus.wb_err, 0);
    chk("midrst.ex_ready",    bus.ex_ready, 0);
    chk("midrst.issue_ready", bus.issue_ready, 1);
    chk("midrst.sr1_busy",    bus.sr1_busy, 0);
    @(posedge clock);
    #1;
    chk("midrst.hold.VSR1", bus.VSR1, 0);
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    reset = 1'b1;
    m_reset();
    #1;
    chk("postrst.VSR1", bus.VSR1, 0);
    chk("postrst.VSR2", bus.VSR2, 0);

    rand_phase(400, 1);
    rand_phase(300, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
